bsg_axil_debug_seq: RTL and testbench

- Parametrised debug-request sequencer. It sits between the DM system-bus master port and a bsg_axil_fifo_master bridge.
- Idle mode: forwards DM system-bus requests to the bridge.
- When any of N harts has debug_req asserted, it takes the bridge and issues four config writes for that hart, in order:
  - set NPC to the debug ROM entry
  - raise the debug IRQ
  - lower the debug IRQ
  - unfreeze
- Generalises the single-hart fixed-address sequencer to N harts, round-robin service, parametrised addresses, and per-hart completion flags.

---
 rtl/bsg_axil_debug_seq.sv | 232 +++++++++++++++++++++++
 tb/tb_bsg_axil_debug_seq.sv | 328 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bsg_axil_debug_seq.sv
// bsg_axil_debug_seq: debug-request sequencer sitting between the DM
// system-bus master and a bsg_axil_fifo_master bridge. DM requests pass
// through when idle; a pending hart debug request takes the bridge for a
// four-write sequence (NPC, IRQ high, IRQ low, unfreeze), served round-robin.
// Optional response timeout: define BSG_DEBUG_SEQ_TIMEOUT_EN.
module bsg_axil_debug_seq #(
    parameter int unsigned                num_harts_p    = 1,
    parameter int unsigned                addr_width_p   = 32,
    parameter int unsigned                data_width_p   = 32,
    parameter logic [data_width_p-1:0]    debug_rom_pc_p = 'h130800,
    parameter logic [addr_width_p-1:0]    npc_addr_p     = 'h200010,
    parameter logic [addr_width_p-1:0]    irq_addr_p     = 'h30c000,
    parameter logic [addr_width_p-1:0]    freeze_addr_p  = 'h200008,
    parameter logic [addr_width_p-1:0]    hart_stride_p  = 'h1000000,
    parameter int unsigned                timeout_p      = 4096
) (
    input  logic                      clk_i,
    input  logic                      reset_i,
    input  logic [num_harts_p-1:0]    debug_req_i,
    input  logic                      dm_req_i,
    input  logic                      dm_we_i,
    input  logic [addr_width_p-1:0]   dm_addr_i,
    input  logic [data_width_p-1:0]   dm_wdata_i,
    input  logic [data_width_p/8-1:0] dm_be_i,
    output logic                      dm_gnt_o,
    output logic                      dm_r_valid_o,
    output logic [data_width_p-1:0]   dm_r_rdata_o,
    output logic                      dm_r_err_o,
    output logic                      fifo_v_o,
    output logic                      fifo_w_o,
    output logic [addr_width_p-1:0]   fifo_addr_o,
    output logic [data_width_p-1:0]   fifo_data_o,
    output logic [data_width_p/8-1:0] fifo_wmask_o,
    input  logic                      fifo_ready_and_i,
    input  logic                      fifo_v_i,
    input  logic [data_width_p-1:0]   fifo_data_i,
    output logic                      fifo_ready_and_o,
    output logic [num_harts_p-1:0]    hart_done_o,
    output logic                      busy_o
);

    localparam int unsigned hart_w_lp = (num_harts_p > 1) ? $clog2(num_harts_p) : 1;

    typedef enum logic [2:0] {
        e_ready,
        e_npc,
        e_hireq,
        e_loreq,
        e_unfreeze
    } state_e;

    state_e                 state_r, next_state;
    logic                   outstanding_r;
    logic                   owner_r;
    logic                   issued_r;
    logic [num_harts_p-1:0] served_r;
    logic [hart_w_lp-1:0]   rr_ptr_r, hart_r;

    logic [num_harts_p-1:0]  pending;
    logic                    pick_v;
    logic [hart_w_lp-1:0]    pick_idx, rr_idx, next_rr;
    logic [addr_width_p-1:0] hart_off;
    logic                    start, issue, resp, late, timeout;
    logic                    seq_resp, done, abort;
    logic [num_harts_p-1:0]  hart_vec, done_vec, abort_vec;

    assign pending  = debug_req_i & ~served_r;
    assign hart_off = addr_width_p'(hart_r) * hart_stride_p;
    assign hart_vec = num_harts_p'(1) << hart_r;
    assign next_rr  = (32'(hart_r) + 1 == num_harts_p) ? '0 : hart_w_lp'(32'(hart_r) + 1);

    // Round-robin pick: first pending hart at or after rr_ptr_r, wrapping.
    always_comb begin
        pick_v   = 1'b0;
        pick_idx = '0;
        rr_idx   = '0;
        for (int unsigned i = 0; i < num_harts_p; i++) begin
            rr_idx = hart_w_lp'((32'(rr_ptr_r) + i) % num_harts_p);
            if (!pick_v && pending[rr_idx]) begin
                pick_v   = 1'b1;
                pick_idx = rr_idx;
            end
        end
    end

`ifdef BSG_DEBUG_SEQ_TIMEOUT_EN
    logic [15:0] tmo_cnt_r;
    logic        stale_r;

    // A timed-out request leaves stale_r set until its late response is
    // swallowed, so that response can never be credited to a newer request.
    assign resp    = fifo_v_i & outstanding_r & ~stale_r;
    assign late    = fifo_v_i & outstanding_r &  stale_r;
    assign timeout = outstanding_r & ~stale_r & ~fifo_v_i & (tmo_cnt_r == 16'(timeout_p - 1));

    // Timeout counter and stale-response tracking.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            tmo_cnt_r <= '0;
            stale_r   <= 1'b0;
        end else begin
            if (issue)
                tmo_cnt_r <= '0;
            else if (outstanding_r && !stale_r)
                tmo_cnt_r <= tmo_cnt_r + 16'd1;
            if (timeout)
                stale_r <= 1'b1;
            else if (late)
                stale_r <= 1'b0;
        end
    end
`else
    assign resp    = fifo_v_i & outstanding_r;
    assign late    = 1'b0;
    assign timeout = 1'b0;
`endif

    assign seq_resp  = resp & owner_r & (state_r != e_ready);
    assign done      = seq_resp & (state_r == e_unfreeze);
    assign abort     = timeout & owner_r & (state_r != e_ready);
    assign done_vec  = done  ? hart_vec : '0;
    assign abort_vec = abort ? hart_vec : '0;
    assign issue     = fifo_v_o & fifo_ready_and_i;

    // Request mux: DM passthrough in e_ready, sequencer writes otherwise.
    always_comb begin
        dm_gnt_o     = 1'b0;
        fifo_v_o     = 1'b0;
        fifo_w_o     = 1'b0;
        fifo_addr_o  = '0;
        fifo_data_o  = '0;
        fifo_wmask_o = '0;
        start        = 1'b0;
        next_state   = state_r;
        case (state_r)
            e_ready: begin
                if (pick_v && !outstanding_r) begin
                    start = 1'b1;
                end else begin
                    fifo_v_o     = dm_req_i & ~outstanding_r;
                    fifo_w_o     = dm_we_i;
                    fifo_addr_o  = dm_addr_i;
                    fifo_data_o  = dm_wdata_i;
                    fifo_wmask_o = dm_be_i;
                    dm_gnt_o     = fifo_v_o & fifo_ready_and_i;
                end
            end
            default: begin
                fifo_v_o     = ~outstanding_r & ~issued_r;
                fifo_w_o     = 1'b1;
                fifo_wmask_o = '1;
                case (state_r)
                    e_npc: begin
                        fifo_addr_o = npc_addr_p + hart_off;
                        fifo_data_o = debug_rom_pc_p;
                        next_state  = e_hireq;
                    end
                    e_hireq: begin
                        fifo_addr_o = irq_addr_p + hart_off;
                        fifo_data_o = data_width_p'(1);
                        next_state  = e_loreq;
                    end
                    e_loreq: begin
                        fifo_addr_o = irq_addr_p + hart_off;
                        fifo_data_o = '0;
                        next_state  = e_unfreeze;
                    end
                    default: begin
                        fifo_addr_o = freeze_addr_p + hart_off;
                        fifo_data_o = '0;
                        next_state  = e_ready;
                    end
                endcase
            end
        endcase
        if (reset_i) begin
            fifo_v_o = 1'b0;
            dm_gnt_o = 1'b0;
            start    = 1'b0;
        end
    end

    assign fifo_ready_and_o = 1'b1;
    assign dm_r_valid_o     = ~reset_i & (resp | timeout) & ~owner_r;
    assign dm_r_err_o       = ~reset_i & timeout & ~owner_r;
    assign dm_r_rdata_o     = (dm_r_valid_o && !timeout) ? fifo_data_i : '0;
    assign hart_done_o      = reset_i ? '0 : done_vec;
    assign busy_o           = ~reset_i & ((state_r != e_ready) | outstanding_r);

    // Sequencer FSM, outstanding/owner tracking and per-hart served flags.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_r       <= e_ready;
            outstanding_r <= 1'b0;
            owner_r       <= 1'b0;
            issued_r      <= 1'b0;
            served_r      <= '0;
            rr_ptr_r      <= '0;
            hart_r        <= '0;
        end else begin
            served_r <= (served_r | done_vec | abort_vec) & debug_req_i;
            if (issue) begin
                outstanding_r <= 1'b1;
                owner_r       <= (state_r != e_ready);
            end else if (resp || late) begin
                outstanding_r <= 1'b0;
            end
            if (issue && state_r != e_ready)
                issued_r <= 1'b1;
            case (state_r)
                e_ready: begin
                    if (start) begin
                        hart_r  <= pick_idx;
                        state_r <= e_npc;
                    end
                end
                default: begin
                    if (seq_resp) begin
                        issued_r <= 1'b0;
                        state_r  <= next_state;
                        if (state_r == e_unfreeze)
                            rr_ptr_r <= next_rr;
                    end else if (abort) begin
                        issued_r <= 1'b0;
                        state_r  <= e_ready;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bsg_axil_debug_seq.sv
// Self-checking bench for bsg_axil_debug_seq (4 harts, default addresses).
module tb_bsg_axil_debug_seq;

    localparam int NH = 4;
    localparam logic [31:0] NPC    = 32'h200010;
    localparam logic [31:0] IRQ    = 32'h30c000;
    localparam logic [31:0] FRZ    = 32'h200008;
    localparam logic [31:0] ROM    = 32'h130800;
    localparam logic [31:0] STRIDE = 32'h1000000;

    logic          clk = 1'b0;
    logic          reset_i = 1'b1;
    logic [NH-1:0] debug_req_i = '0;
    logic          dm_req_i = 1'b0, dm_we_i = 1'b0;
    logic [31:0]   dm_addr_i = '0, dm_wdata_i = '0;
    logic [3:0]    dm_be_i = '0;
    logic          dm_gnt_o, dm_r_valid_o, dm_r_err_o;
    logic [31:0]   dm_r_rdata_o;
    logic          fifo_v_o, fifo_w_o;
    logic [31:0]   fifo_addr_o, fifo_data_o;
    logic [3:0]    fifo_wmask_o;
    logic          fifo_ready_and_i = 1'b1;
    logic          fifo_v_i = 1'b0;
    logic [31:0]   fifo_data_i = '0;
    logic          fifo_ready_and_o;
    logic [NH-1:0] hart_done_o;
    logic          busy_o;

    always #5 clk = ~clk;

    bsg_axil_debug_seq #(.num_harts_p(NH)) dut (
        .clk_i(clk), .reset_i(reset_i), .debug_req_i(debug_req_i),
        .dm_req_i(dm_req_i), .dm_we_i(dm_we_i), .dm_addr_i(dm_addr_i),
        .dm_wdata_i(dm_wdata_i), .dm_be_i(dm_be_i), .dm_gnt_o(dm_gnt_o),
        .dm_r_valid_o(dm_r_valid_o), .dm_r_rdata_o(dm_r_rdata_o), .dm_r_err_o(dm_r_err_o),
        .fifo_v_o(fifo_v_o), .fifo_w_o(fifo_w_o), .fifo_addr_o(fifo_addr_o),
        .fifo_data_o(fifo_data_o), .fifo_wmask_o(fifo_wmask_o),
        .fifo_ready_and_i(fifo_ready_and_i), .fifo_v_i(fifo_v_i), .fifo_data_i(fifo_data_i),
        .fifo_ready_and_o(fifo_ready_and_o), .hart_done_o(hart_done_o), .busy_o(busy_o)
    );

    typedef struct packed {
        logic        w;
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  mask;
    } req_t;

    req_t        req_log[$];
    int          done_log[$];
    logic [31:0] dmr_log[$];
    int          gnt_cnt = 0, err_pulses = 0;
    int          checks = 0, errors = 0;
    int          lat_cfg = 1, resp_cnt = 0, stall_cycles = 0;
    logic [31:0] resp_data = '0;
    bit          tb_out = 1'b0;
    int          rr_model = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Bus monitor: logs accepted requests, DM responses, grants, done pulses.
    always @(negedge clk) begin
        if (!reset_i) begin
            if (tb_out) check("no_v_while_outstanding", 64'(fifo_v_o), 64'd0);
            if (fifo_v_o && fifo_ready_and_i) begin
                req_log.push_back('{w: fifo_w_o, addr: fifo_addr_o, data: fifo_data_o, mask: fifo_wmask_o});
                resp_cnt = lat_cfg;
                tb_out   = 1'b1;
            end
            if (dm_gnt_o) gnt_cnt++;
            if (dm_r_valid_o) dmr_log.push_back(dm_r_rdata_o);
            if (dm_r_err_o) err_pulses++;
            for (int h = 0; h < NH; h++)
                if (hart_done_o[h]) done_log.push_back(h);
        end
        if (fifo_v_i) tb_out = 1'b0;
    end

    // Bridge model: fixed-latency response, optional ready stall.
    always @(posedge clk) begin
        #1;
        fifo_v_i    = 1'b0;
        fifo_data_i = '0;
        if (resp_cnt > 0) begin
            resp_cnt--;
            if (resp_cnt == 0) begin
                fifo_v_i    = 1'b1;
                fifo_data_i = resp_data;
            end
        end
        if (stall_cycles > 0) begin
            fifo_ready_and_i = 1'b0;
            stall_cycles--;
        end else begin
            fifo_ready_and_i = 1'b1;
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic drive_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic check_writes(input string tag, input int idx, input int h);
        logic [31:0] a[4];
        logic [31:0] d[4];
        a[0] = NPC + 32'(h) * STRIDE; d[0] = ROM;
        a[1] = IRQ + 32'(h) * STRIDE; d[1] = 32'd1;
        a[2] = IRQ + 32'(h) * STRIDE; d[2] = 32'd0;
        a[3] = FRZ + 32'(h) * STRIDE; d[3] = 32'd0;
        for (int k = 0; k < 4; k++) begin
            if (req_log.size() > idx + k) begin
                check({tag, "_w"},    64'(req_log[idx+k].w),    64'd1);
                check({tag, "_addr"}, 64'(req_log[idx+k].addr), 64'(a[k]));
                check({tag, "_data"}, 64'(req_log[idx+k].data), 64'(d[k]));
                check({tag, "_mask"}, 64'(req_log[idx+k].mask), 64'hf);
            end else begin
                check({tag, "_missing"}, 64'(req_log.size()), 64'(idx + 4));
            end
        end
    endtask

    task automatic dm_op(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [3:0] be, input int lat, input string tag);
        int base, g0, d0;
        bit got;
        base = req_log.size(); g0 = gnt_cnt; d0 = dmr_log.size();
        lat_cfg = lat;
        resp_data = $urandom;
        drive_edge();
        dm_req_i = 1'b1; dm_we_i = we; dm_addr_i = addr; dm_wdata_i = wdata; dm_be_i = be;
        got = 1'b0;
        for (int i = 0; i < 300 && !got; i++) begin
            tick();
            if (dm_gnt_o) got = 1'b1;
        end
        check({tag, "_gnt_seen"}, 64'(got), 64'd1);
        drive_edge();
        dm_req_i = 1'b0; dm_we_i = 1'b0; dm_addr_i = '0; dm_wdata_i = '0; dm_be_i = '0;
        for (int i = 0; i < 300 && dmr_log.size() == d0; i++) tick();
        check({tag, "_rsp_seen"}, 64'(dmr_log.size()), 64'(d0 + 1));
        if (dmr_log.size() > d0) check({tag, "_rdata"}, 64'(dmr_log[d0]), 64'(resp_data));
        check({tag, "_gnt_count"}, 64'(gnt_cnt - g0), 64'd1);
        if (req_log.size() > base) begin
            check({tag, "_req"}, 64'({req_log[base].w, req_log[base].addr, req_log[base].mask}),
                  64'({we, addr, be}));
            if (we) check({tag, "_wdata"}, 64'(req_log[base].data), 64'(wdata));
        end else begin
            check({tag, "_req_missing"}, 64'(req_log.size()), 64'(base + 1));
        end
    endtask

    task automatic run_seq(input logic [NH-1:0] mask, input int lat, input string tag);
        int order[$];
        int base, d0, n0;
        logic [NH-1:0] left;
        base = req_log.size(); d0 = done_log.size();
        left = mask;
        while (left != '0) begin
            if (left[rr_model]) begin
                order.push_back(rr_model);
                left[rr_model] = 1'b0;
            end
            rr_model = (rr_model + 1) % NH;
        end
        lat_cfg = lat;
        drive_edge();
        debug_req_i = mask;
        for (int i = 0; i < 100 * NH && done_log.size() < d0 + order.size(); i++) tick();
        check({tag, "_done_count"}, 64'(done_log.size() - d0), 64'(order.size()));
        for (int i = 0; i < order.size(); i++) begin
            if (done_log.size() > d0 + i)
                check({tag, "_done_order"}, 64'(done_log[d0+i]), 64'(order[i]));
            check_writes(tag, base + 4 * i, order[i]);
        end
        n0 = req_log.size();
        for (int i = 0; i < 20; i++) tick();
        check({tag, "_no_resequence"}, 64'(req_log.size()), 64'(n0));
        check({tag, "_idle"}, 64'(busy_o), 64'd0);
        drive_edge();
        debug_req_i = '0;
        tick(); tick();
    endtask

    initial begin
        int base, d0, g0, stable;
        logic [31:0] a;
        bit got, done_at_gnt;

        // Reset state
        repeat (3) @(posedge clk);
        #1 reset_i = 1'b0;
        tick();
        check("rst_fifo_v", 64'(fifo_v_o), 64'd0);
        check("rst_dm_gnt", 64'(dm_gnt_o), 64'd0);
        check("rst_dm_r_valid", 64'(dm_r_valid_o), 64'd0);
        check("rst_dm_r_err", 64'(dm_r_err_o), 64'd0);
        check("rst_hart_done", 64'(hart_done_o), 64'd0);
        check("rst_busy", 64'(busy_o), 64'd0);
        check("rst_ready_o", 64'(fifo_ready_and_o), 64'd1);

        // DM read passthrough
        d0 = done_log.size();
        dm_op(1'b0, 32'h80000000, 32'h0, 4'hf, 5, "dm_read");
        check("dm_read_no_done", 64'(done_log.size()), 64'(d0));

        // Single-hart sequence, then two harts round-robin from hart 1
        run_seq(4'b0001, 2, "seq_h0");
        run_seq(4'b1010, 1, "seq_h13");

        // DM request together with a debug request: sequence wins
        base = req_log.size(); d0 = done_log.size(); g0 = gnt_cnt;
        lat_cfg = 2;
        resp_data = $urandom;
        a = $urandom;
        drive_edge();
        debug_req_i = 4'b0100;
        dm_req_i = 1'b1; dm_we_i = 1'b0; dm_addr_i = a; dm_be_i = 4'hf;
        got = 1'b0; done_at_gnt = 1'b0;
        for (int i = 0; i < 300 && !got; i++) begin
            tick();
            if (dm_gnt_o) begin
                got = 1'b1;
                done_at_gnt = (done_log.size() == d0 + 1);
            end
        end
        check("prio_gnt_seen", 64'(got), 64'd1);
        check("prio_gnt_after_done", 64'(done_at_gnt), 64'd1);
        drive_edge();
        dm_req_i = 1'b0; dm_addr_i = '0; dm_be_i = '0;
        for (int i = 0; i < 100 && dmr_log.size() == 0; i++) tick();
        for (int i = 0; i < 20; i++) tick();
        if (dmr_log.size() > 0) check("prio_rdata", 64'(dmr_log[dmr_log.size()-1]), 64'(resp_data));
        check("prio_gnt_count", 64'(gnt_cnt - g0), 64'd1);
        check_writes("prio_seq", base, 2);
        if (req_log.size() > base + 4)
            check("prio_dm_addr", 64'(req_log[base+4].addr), 64'(a));
        else
            check("prio_dm_missing", 64'(req_log.size()), 64'(base + 5));
        rr_model = 3;
        drive_edge();
        debug_req_i = '0;
        tick(); tick();

        // Bridge stalls ready during e_hireq
        base = req_log.size(); d0 = done_log.size();
        lat_cfg = 1;
        drive_edge();
        debug_req_i = 4'b0010;
        for (int i = 0; i < 100 && req_log.size() < base + 1; i++) tick();
        stall_cycles = 10;
        stable = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (fifo_v_o && fifo_addr_o == IRQ + STRIDE && fifo_data_o == 32'd1) stable++;
        end
        check("stall_stable_cycles", 64'(stable), 64'd9);
        check("stall_no_advance", 64'(req_log.size()), 64'(base + 1));
        for (int i = 0; i < 200 && done_log.size() == d0; i++) tick();
        check("stall_done", 64'(done_log.size()), 64'(d0 + 1));
        check_writes("stall_seq", base, 1);
        rr_model = 2;
        drive_edge();
        debug_req_i = '0;
        tick(); tick();

        // Reset pulsed during e_loreq, in-flight response must be ignored
        base = req_log.size(); d0 = done_log.size(); g0 = dmr_log.size();
        lat_cfg = 3;
        drive_edge();
        debug_req_i = 4'b0100;
        for (int i = 0; i < 200 && req_log.size() < base + 3; i++) tick();
        check("rst_mid_reached_loreq", 64'(req_log.size()), 64'(base + 3));
        drive_edge();
        reset_i = 1'b1;
        debug_req_i = '0;
        tick();
        drive_edge();
        reset_i = 1'b0;
        tick();
        check("rst_mid_fifo_v", 64'(fifo_v_o), 64'd0);
        check("rst_mid_busy", 64'(busy_o), 64'd0);
        check("rst_mid_done", 64'(hart_done_o), 64'd0);
        check("rst_mid_dm_valid", 64'(dm_r_valid_o), 64'd0);
        for (int i = 0; i < 6; i++) tick();
        check("rst_mid_late_rsp_dropped", 64'(dmr_log.size()), 64'(g0));
        check("rst_mid_no_done", 64'(done_log.size()), 64'(d0));
        check("rst_mid_no_new_req", 64'(req_log.size()), 64'(base + 3));
        check("rst_mid_idle", 64'(busy_o), 64'd0);
        rr_model = 0;

        // All harts at once after reset: 0,1,2,3
        run_seq(4'b1111, 2, "seq_all");

        // Randomised mix of DM accesses and debug requests
        for (int it = 0; it < 8; it++) begin
            if ($urandom_range(1, 0) == 1) begin
                dm_op(1'($urandom), $urandom, $urandom, 4'($urandom_range(15, 1)),
                      int'($urandom_range(6, 1)), "rnd_dm");
            end else begin
                run_seq(NH'($urandom_range(15, 1)), int'($urandom_range(4, 1)), "rnd_seq");
            end
        end

        check("no_err_pulses", 64'(err_pulses), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
